// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX/MEM boundary register with valid/ready flow control, 2-entry skid buffer and flush
module ex_mem_skid_reg #(
    parameter int DATA_W    = 128,
    parameter int PC_W      = 11,
    parameter int REGADDR_W = 7,
    parameter int CTRL_W    = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PC_W-1:0]      in_jump_pc,
    input  logic                 in_zero,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    in_store_data,
    input  logic [REGADDR_W-1:0] in_rt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PC_W-1:0]      out_jump_pc,
    output logic                 out_zero,
    output logic [DATA_W-1:0]    out_alu_result,
    output logic [DATA_W-1:0]    out_store_data,
    output logic [REGADDR_W-1:0] out_rt,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int PW = CTRL_W + PC_W + 1 + 2 * DATA_W + REGADDR_W;
    logic [PW-1:0]     r_main, r_skid;
    logic              r_main_v, r_skid_v, r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [PW-1:0]     w_in_pl;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_in_fire, w_out_fire;
    assign w_in_pl    = {in_ctrl, in_jump_pc, in_zero, in_alu_result, in_store_data, in_rt};
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_v & out_ready;
    assign {w_main_ctrl, out_jump_pc, out_zero, out_alu_result, out_store_data, out_rt} = r_main;
    assign out_ctrl   = r_main_v ? w_main_ctrl : '0;
    assign out_valid  = r_main_v;
    assign in_ready   = r_in_ready;
    assign occupancy  = {1'b0, r_main_v} + {1'b0, r_skid_v};
    assign stall_cnt  = r_stall_cnt;
    // Entry storage: main feeds the outputs, skid catches the one beat accepted while main is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (!r_main_v) begin
            if (w_in_fire) begin
                r_main   <= w_in_pl;
                r_main_v <= 1'b1;
            end
        end else if (!r_skid_v) begin
            if (w_out_fire && w_in_fire) begin
                r_main <= w_in_pl;
            end else if (w_out_fire) begin
                r_main_v <= 1'b0;
            end else if (w_in_fire) begin
                r_skid     <= w_in_pl;
                r_skid_v   <= 1'b1;
                r_in_ready <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_main     <= r_skid;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end
    end
    // Saturating count of cycles the MEM stage held off a valid payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_v && !out_ready && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: directed and random checks of ex_mem_skid_reg against a queue model
module tb_ex_mem_skid_reg;
    typedef struct packed {
        logic [4:0]   ctrl;
        logic [10:0]  pc;
        logic         z;
        logic [127:0] alu;
        logic [127:0] sd;
        logic [6:0]   rt;
    } pl_t;
    logic         clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    pl_t          drv = '0;
    logic         in_ready, out_valid, out_zero;
    logic [4:0]   out_ctrl;
    logic [10:0]  out_jump_pc;
    logic [127:0] out_alu_result, out_store_data;
    logic [6:0]   out_rt;
    logic [1:0]   occupancy;
    logic [2:0]   stall_cnt;
    int           checks = 0, errors = 0;
    pl_t          q[$];
    logic [2:0]   m_cnt = 0;
    ex_mem_skid_reg #(.CNT_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(drv.ctrl), .in_jump_pc(drv.pc), .in_zero(drv.z), .in_alu_result(drv.alu),
        .in_store_data(drv.sd), .in_rt(drv.rt), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_jump_pc(out_jump_pc), .out_zero(out_zero),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data), .out_rt(out_rt),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic pl_t mk(input logic [127:0] a, input logic [4:0] c);
        pl_t p;
        p.ctrl = c; p.pc = a[10:0] ^ 11'h5a5; p.z = a[0]; p.alu = a; p.sd = ~a; p.rt = a[6:0] + 7'd3;
        return p;
    endfunction
    task automatic step(input logic iv, input logic ordy, input logic fl, input pl_t p);
        in_valid = iv; out_ready = ordy; flush = fl; drv = p;
        @(posedge clk); #1;
    endtask
    // Model: FIFO of at most two payloads; acceptance whenever fewer than two are held
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_cnt <= 0;
        end else begin
            automatic bit inf = in_valid && q.size() < 2;
            automatic bit outf = q.size() > 0 && out_ready;
            if (q.size() > 0 && !out_ready && m_cnt != 3'd7) m_cnt <= m_cnt + 3'd1;
            if (flush) q.delete();
            else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(drv);
            end
        end
    end
    // Compare every cycle outside reset
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("occupancy", occupancy, q.size());
            chk("stall_cnt", stall_cnt, m_cnt);
            chk("out_ctrl", out_ctrl, q.size() > 0 ? q[0].ctrl : 5'd0);
            if (q.size() > 0) begin
                chk("out_jump_pc", out_jump_pc, q[0].pc);
                chk("out_zero", out_zero, q[0].z);
                chk("out_alu_result", out_alu_result, q[0].alu);
                chk("out_store_data", out_store_data, q[0].sd);
                chk("out_rt", out_rt, q[0].rt);
            end
        end
    end
    initial begin
        #23 reset = 1;
        @(posedge clk); #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_ctrl", out_ctrl, 0);
        chk("rst out_alu", out_alu_result, 0);
        chk("rst out_sd", out_store_data, 0);
        chk("rst occupancy", occupancy, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, mk(k, 5'h3));
            chk("b2b out_valid", out_valid, 1);
            chk("b2b alu", out_alu_result, k);
            chk("b2b occupancy", occupancy, 1);
            chk("b2b in_ready", in_ready, 1);
        end
        step(0, 1, 0, '0);
        chk("drain out_valid", out_valid, 0);
        step(1, 0, 0, mk(128'hA, 5'h2));
        chk("skidA occupancy", occupancy, 1);
        step(1, 0, 0, mk(128'hB, 5'h2));
        chk("skidB occupancy", occupancy, 2);
        chk("skidB in_ready", in_ready, 0);
        chk("skidB alu", out_alu_result, 128'hA);
        step(0, 1, 0, '0);
        chk("popA alu", out_alu_result, 128'hB);
        chk("popA in_ready", in_ready, 1);
        step(0, 1, 0, '0);
        chk("popB out_valid", out_valid, 0);
        step(1, 0, 0, mk(128'hD, 5'h1f));
        step(1, 0, 1, mk(128'hC, 5'h1f));
        chk("flush1 out_valid", out_valid, 0);
        chk("flush1 occupancy", occupancy, 0);
        step(1, 0, 0, mk(128'hD, 5'h1f));
        step(1, 0, 0, mk(128'hE, 5'h1f));
        chk("two out_ctrl", out_ctrl, 5'h1f);
        step(1, 0, 1, mk(128'hC, 5'h1f));
        chk("flush2 out_valid", out_valid, 0);
        chk("flush2 out_ctrl", out_ctrl, 0);
        chk("flush2 occupancy", occupancy, 0);
        chk("flush2 in_ready", in_ready, 1);
        step(0, 1, 0, '0);
        chk("noC out_valid", out_valid, 0);
        reset = 0; #10 reset = 1;
        step(1, 0, 0, mk(128'h55, 5'h4));
        chk("sat start", stall_cnt, 0);
        repeat (3) step(0, 0, 0, '0);
        chk("sat three", stall_cnt, 3);
        repeat (7) step(0, 0, 0, '0);
        chk("sat seven", stall_cnt, 7);
        step(0, 0, 1, '0);
        chk("sat flush", stall_cnt, 7);
        chk("sat flush valid", out_valid, 0);
        step(1, 0, 0, mk(128'h71, 5'h1f));
        step(1, 0, 0, mk(128'h72, 5'h1f));
        chk("arst pre occ", occupancy, 2);
        #3 reset = 0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst in_ready", in_ready, 1);
        chk("arst stall_cnt", stall_cnt, 0);
        chk("arst occupancy", occupancy, 0);
        chk("arst out_ctrl", out_ctrl, 0);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        step(1, 1, 0, mk(128'h99, 5'h6));
        chk("arst first alu", out_alu_result, 128'h99);
        chk("arst first valid", out_valid, 1);
        for (int i = 0; i < 10000; i++) begin
            pl_t p;
            p.ctrl = 5'($urandom); p.pc = 11'($urandom); p.z = 1'($urandom);
            p.alu = {$urandom, $urandom, $urandom, $urandom};
            p.sd = {$urandom, $urandom, $urandom, $urandom};
            p.rt = 7'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, p);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
